// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the ALU result register and the BCD converter.
`timescale 1ns/1ps
interface bin2bcd_seq_if #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) ();
  logic                start;
  logic [IN_W-1:0]     bin;
  logic                is_signed;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                neg;
  logic                ovf;

  modport master (
    output start, bin, is_signed,
    input  busy, done, bcd, neg, ovf
  );

  modport slave (
    input  start, bin, is_signed,
    output busy, done, bcd, neg, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed-BCD converter, one input bit per clock,
// with sign extraction and sticky overflow for the display digit decoders.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | one correct-and-shift step per clock, IN_W steps
// DONE  | result registered, done pulse for this cycle
`timescale 1ns/1ps
module bin2bcd_seq #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  cv
);

  localparam int            BW   = 4 * DIGITS;
  localparam int            CW   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IN_W-1:0] mag;
  logic [BW-1:0]   scratch;
  logic [CW-1:0]   cnt;
  logic            sign_q;
  logic            ovf_sticky;
  logic [BW-1:0]   bcd_q;
  logic            neg_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   scratch_nxt;
  logic [IN_W-1:0] mag_nxt;
  logic            carry_out;
  logic            accept;
  logic            last_shift;
  logic            in_neg;

  // per-digit add-3 before the shift; a digit of 5..9 becomes 8..C, never wider than 4 bits
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    {carry_out, scratch_nxt, mag_nxt} = {adj, mag, 1'b0};
  end

  assign in_neg = cv.is_signed & cv.bin[IN_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_shift = 1'b0;
    case (state)
      IDLE: begin
        if (cv.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last_shift = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag        <= '0;
      scratch    <= '0;
      cnt        <= '0;
      sign_q     <= 1'b0;
      ovf_sticky <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // flags decoded from next state so they are plain flops at the ports
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
      if (accept) begin
        mag        <= in_neg ? (~cv.bin + IN_W'(1)) : cv.bin;
        sign_q     <= in_neg;
        scratch    <= '0;
        ovf_sticky <= 1'b0;
        cnt        <= '0;
      end else if (state == SHIFT) begin
        mag        <= mag_nxt;
        scratch    <= scratch_nxt;
        ovf_sticky <= ovf_sticky | carry_out;
        cnt        <= cnt + CW'(1);
        if (last_shift) begin
          bcd_q <= scratch_nxt;
          neg_q <= sign_q;
          ovf_q <= ovf_sticky | carry_out;
        end
      end
    end
  end

  assign cv.busy = busy_q;
  assign cv.done = done_q;
  assign cv.bcd  = bcd_q;
  assign cv.neg  = neg_q;
  assign cv.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench: 3-digit and 2-digit converters share one stimulus stream and are
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bin2bcd_seq;
  localparam int IN_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start;
  logic [7:0] bin;
  logic       is_signed;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.IN_W(IN_W), .DIGITS(3)) if3 ();
  bin2bcd_seq_if #(.IN_W(IN_W), .DIGITS(2)) if2 ();

  assign if3.start     = start;
  assign if3.bin       = bin;
  assign if3.is_signed = is_signed;
  assign if2.start     = start;
  assign if2.bin       = bin;
  assign if2.is_signed = is_signed;

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(3)) u3 (.clk(clk), .rst(rst), .cv(if3));
  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(2)) u2 (.clk(clk), .rst(rst), .cv(if2));

  typedef struct {
    logic [11:0] bcd;
    logic        neg;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];
  exp_t last3;
  exp_t last2;
  int   cyc     = 0;
  int   rem     = 0;
  int   acc_cnt = 0;
  int   errors  = 0;
  int   checks  = 0;

  function automatic exp_t ref_conv(input logic [7:0] b, input logic s, input int d, input int due);
    exp_t r;
    int   m;
    int   lim;
    int   v;
    m   = (s && b[7]) ? 256 - int'(b) : int'(b);
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    r.ovf = (m >= lim);
    v     = m % lim;
    r.bcd = '0;
    for (int i = 0; i < d; i++) begin
      r.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    r.neg = s && b[7];
    r.due = due;
    return r;
  endfunction

  function automatic exp_t zero_exp();
    exp_t r;
    r.bcd = '0;
    r.neg = 1'b0;
    r.ovf = 1'b0;
    r.due = 0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // reference model: accepts start only when idle, busy for IN_W+1 cycles after accept
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0;
      q3.delete();
      q2.delete();
    end else begin
      cyc++;
      if (rem == 0) begin
        if (start) begin
          q3.push_back(ref_conv(bin, is_signed, 3, cyc + IN_W));
          q2.push_back(ref_conv(bin, is_signed, 2, cyc + IN_W));
          rem = IN_W + 1;
          acc_cnt++;
        end
      end else begin
        rem--;
      end
    end
  end

  task automatic mon(input int id, input logic done, input logic [11:0] bcd,
                     input logic neg, input logic ovf);
    exp_t  e;
    exp_t  l;
    int    sz;
    string tag;
    tag = (id == 0) ? "d3" : "d2";
    sz  = (id == 0) ? q3.size() : q2.size();
    l   = (id == 0) ? last3 : last2;
    if (done) begin
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_spurious_done: done=1 at cycle %0d, required done=0", tag, cyc);
      end else begin
        if (id == 0) e = q3.pop_front();
        else         e = q2.pop_front();
        chk({tag, "_done_cycle"}, cyc, e.due);
        chk({tag, "_bcd"}, bcd, e.bcd);
        chk({tag, "_neg"}, neg, e.neg);
        chk({tag, "_ovf"}, ovf, e.ovf);
        if (id == 0) last3 = e;
        else         last2 = e;
      end
    end else begin
      if (sz != 0) begin
        e = (id == 0) ? q3[0] : q2[0];
        if (e.due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL %s_missing_done: done=0 at cycle %0d, required done=1", tag, cyc);
          if (id == 0) void'(q3.pop_front());
          else         void'(q2.pop_front());
        end
      end
      chk({tag, "_hold_bcd"}, bcd, l.bcd);
      chk({tag, "_hold_neg"}, neg, l.neg);
      chk({tag, "_hold_ovf"}, ovf, l.ovf);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last3 = zero_exp();
      last2 = zero_exp();
    end else begin
      chk("d3_busy", 32'(if3.busy), 32'(rem != 0));
      chk("d2_busy", 32'(if2.busy), 32'(rem != 0));
      mon(0, if3.done, if3.bcd, if3.neg, if3.ovf);
      mon(1, if2.done, {4'h0, if2.bcd}, if2.neg, if2.ovf);
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_d3_busy"}, if3.busy, 0);
    chk({tag, "_d3_done"}, if3.done, 0);
    chk({tag, "_d3_bcd"},  if3.bcd,  0);
    chk({tag, "_d3_neg"},  if3.neg,  0);
    chk({tag, "_d3_ovf"},  if3.ovf,  0);
    chk({tag, "_d2_busy"}, if2.busy, 0);
    chk({tag, "_d2_done"}, if2.done, 0);
    chk({tag, "_d2_bcd"},  if2.bcd,  0);
    chk({tag, "_d2_neg"},  if2.neg,  0);
    chk({tag, "_d2_ovf"},  if2.ovf,  0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (rem == 0 && q3.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    chk("idle_timeout", 32'(rem == 0 && q3.size() == 0 && q2.size() == 0), 1);
  endtask

  task automatic wait_accept();
    int a0;
    a0 = acc_cnt;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (acc_cnt != a0) break;
    end
    chk("accept_timeout", 32'(acc_cnt != a0), 1);
  endtask

  // one-cycle start pulse; optionally scramble inputs while the conversion runs
  task automatic convert(input logic [7:0] b, input logic s, input bit scramble);
    start     = 1'b1;
    bin       = b;
    is_signed = s;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      bin       = 8'($urandom);
      is_signed = 1'($urandom);
    end
    wait_idle();
  endtask

  logic [7:0] edge_vals [12] = '{8'd0, 8'd1, 8'd9, 8'd10, 8'd99, 8'd100,
                                 8'd127, 8'd128, 8'd255, 8'h81, 8'h7F, 8'hFE};

  initial begin
    start     = 1'b0;
    bin       = '0;
    is_signed = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("init");
    rst = 1'b0;
    @(negedge clk);

    convert(8'd255, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    convert(8'h80, 1'b1, 1'b1);
    convert(8'hFF, 1'b1, 1'b1);
    convert(8'h00, 1'b1, 1'b1);

    // start during busy must be ignored, not queued
    start = 1'b1;
    bin   = 8'd42;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'd99;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);

    // reset in the middle of a conversion
    start = 1'b1;
    bin   = 8'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    convert(8'd7, 1'b0, 1'b0);

    convert(8'd199, 1'b0, 1'b0);
    convert(8'd42, 1'b0, 1'b0);

    // start held high: back-to-back conversions
    start = 1'b1;
    bin   = 8'd1;
    wait_accept();
    bin = 8'd2;
    wait_accept();
    bin = 8'd3;
    wait_accept();
    start = 1'b0;
    wait_idle();

    foreach (edge_vals[i]) begin
      convert(edge_vals[i], 1'b0, 1'b1);
      convert(edge_vals[i], 1'b1, 1'b1);
    end

    for (int n = 0; n < 40; n++) begin
      convert(8'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    chk("scoreboard_empty", 32'(q3.size() + q2.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
